// File: rtl/rv32_grng_clt_unit_if.sv
// Request/response bundle for the central-limit Gaussian RNG unit.
// The master side is the requester/consumer; the slave side is the unit itself.
interface rv32_grng_clt_unit_if #(
  parameter int OUT_W = 32
);
  typedef struct packed {
    logic enable;    // request one sample
    logic set_seed;  // reseed all lanes (wins over enable)
  } grng_ctrl_t;

  grng_ctrl_t         ctrl_i;
  logic [31:0]        seed_i;
  logic               out_ready_i;
  logic               out_valid_o;
  logic [OUT_W-1:0]   out_data_o;

  modport master (
    output ctrl_i, seed_i, out_ready_i,
    input  out_valid_o, out_data_o
  );

  modport slave (
    input  ctrl_i, seed_i, out_ready_i,
    output out_valid_o, out_data_o
  );
endinterface

// File: rtl/rv32_grng_clt_unit.sv
// Gaussian RNG functional unit: sums the top SOURCE_W bits of NUM_SOURCES
// independent 32-bit Galois LFSR lanes and removes the mean, giving a
// zero-mean central-limit approximation of a normal sample.
// Build macro GRNG_PIPE_EN: adds register stage S1 between the adder tree and
// the output register (latency 2 instead of 1, still one sample per cycle).
module rv32_grng_clt_unit #(
  parameter int NUM_SOURCES = 4,
  parameter int SOURCE_W    = 12,
  parameter int OUT_W       = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  rv32_grng_clt_unit_if.slave   bus
);
  localparam logic [31:0]      GOLDEN = 32'h9E3779B9;
  localparam logic [31:0]      POLY   = 32'h80200003;
  // Mean of the raw slice sum; subtracting it centres the output on zero.
  localparam logic [OUT_W-1:0] BIAS   = OUT_W'(NUM_SOURCES) << (SOURCE_W - 1);

  generate
    if (NUM_SOURCES < 1 || SOURCE_W < 1 || SOURCE_W > 32 ||
        OUT_W < SOURCE_W + $clog2(NUM_SOURCES) + 1) begin : g_bad_params
      $error("rv32_grng_clt_unit: illegal NUM_SOURCES/SOURCE_W/OUT_W combination");
    end
  endgenerate

  // An all-zero Galois LFSR never leaves zero, so zero states are replaced by 1.
  function automatic logic [31:0] nonzero(input logic [31:0] v);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  logic [31:0]      lane_q   [NUM_SOURCES];
  logic [31:0]      lane_d   [NUM_SOURCES];
  logic [31:0]      lane_rst [NUM_SOURCES];
  logic [OUT_W-1:0] sample_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             set_seed, advance, accept;

  // The whole datapath moves only when the output register is empty or draining.
  assign set_seed = bus.ctrl_i.set_seed;
  assign advance  = ~out_valid_q | bus.out_ready_i;
  assign accept   = bus.ctrl_i.enable & ~set_seed & advance;

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_lane
      // Per-lane decorrelation constant (golden-ratio multiple of the lane index).
      localparam logic [31:0] LANE_K = 32'(gi) * GOLDEN;
      assign lane_rst[gi] = nonzero(LANE_K ^ 32'h1);
      assign lane_d[gi]   = set_seed ? nonzero(bus.seed_i ^ LANE_K) :
                            accept   ? (lane_q[gi][0] ? ((lane_q[gi] >> 1) ^ POLY)
                                                      : (lane_q[gi] >> 1)) :
                                       lane_q[gi];
    end
  endgenerate

  // Lane state register: reseed, step on accept, otherwise frozen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SOURCES; i++) lane_q[i] <= lane_rst[i];
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) lane_q[i] <= lane_d[i];
    end
  end

  // Adder tree over the pre-step lane slices, then remove the bias.
  always_comb begin
    sample_d = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      sample_d = sample_d + OUT_W'(lane_q[i][31 -: SOURCE_W]);
    end
    sample_d = sample_d - BIAS;
  end

`ifdef GRNG_PIPE_EN
  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_data_q, s1_data_d;

  // Two-stage next state: S1 captures the adder result, output takes S1.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (set_seed) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (advance) begin
      s1_valid_d  = accept;
      if (accept) s1_data_d = sample_d;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = s1_data_q;
    end
  end

  // S1 register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end
`else
  // Single stage: an accepted request lands in the output register next cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (set_seed) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      out_valid_d = accept;
      if (accept) out_data_d = sample_d;
    end
  end
`endif

  // Output register; data is held untouched while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
endmodule
